// File: rtl/blink_scheduler.sv
// blink_scheduler
// Shared time base and offset scheduler for four blink channels. A single
// free-running count feeds every blinker; each channel owns a 16-bit phase
// offset. In CHASE mode every 1024-count blink period rotates all offsets
// forward by CHASE_STEP, producing a travelling pattern.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   ena               count enable (freezes count and period events when 0)
//   mode[1:0]         00 stop, 01 static, 10 chase, 11 same as 01
//   cfg_valid/chan/offset, cfg_ready
//                     offset write handshake (blocked while chasing)
//   count[15:0]       shared count
//   offsets[63:0]     channel i offset at [16i+15:16i]
//   period_tick       one-cycle pulse after each 1024-count period wrap
//   state[1:0]        00 IDLE, 01 RUN, 10 CHASE
module blink_scheduler #(
   parameter logic [15:0] PHASE_STEP = 16'd256,
   parameter logic [15:0] CHASE_STEP = 16'd64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [1:0]  mode,
   input  logic        cfg_valid,
   input  logic [1:0]  cfg_chan,
   input  logic [15:0] cfg_offset,
   output logic        cfg_ready,
   output logic [15:0] count,
   output logic [63:0] offsets,
   output logic        period_tick,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      CHASE = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [63:0] offsets_q, offsets_d;
   logic        tick_q, tick_d;

   logic stop_mode, chase_mode, advance, wrap;

   assign stop_mode  = (mode == 2'b00);
   assign chase_mode = (mode == 2'b10);
   // A stop request takes priority over counting: the edge that drops to
   // IDLE must not advance.
   assign advance    = ena && (state_q != IDLE) && !stop_mode;
   assign wrap       = advance && (count_q[9:0] == 10'h3FF);

   assign cfg_ready  = (state_q != CHASE);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      offsets_d = offsets_q;
      tick_d    = wrap;

      if (advance)
         count_d = count_q + 16'd1;

      unique case (state_q)
         IDLE:    if (!stop_mode) state_d = RUN;
         RUN:     if (stop_mode) state_d = IDLE;
                  else if (wrap && chase_mode) state_d = CHASE;
         CHASE:   if (stop_mode) state_d = IDLE;
                  else if (wrap && mode[0]) state_d = RUN;
         default: state_d = IDLE;
      endcase

      // Increment on every wrap that ends up in CHASE: covers both the entry
      // wrap and wraps while staying in CHASE, but not the exit wrap.
      if (wrap && (state_d == CHASE)) begin
         for (int i = 0; i < 4; i++)
            offsets_d[16*i +: 16] = offsets_q[16*i +: 16] + CHASE_STEP;
      end

      // A write lands after the increment so it wins on the entry edge.
      if (cfg_valid && cfg_ready)
         offsets_d[{cfg_chan, 4'b0000} +: 16] = cfg_offset;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= 16'd0;
         tick_q  <= 1'b0;
         for (int i = 0; i < 4; i++)
            offsets_q[16*i +: 16] <= 16'(PHASE_STEP * i);
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         tick_q    <= tick_d;
         offsets_q <= offsets_d;
      end
   end

   assign state       = state_q;
   assign count       = count_q;
   assign offsets     = offsets_q;
   assign period_tick = tick_q;

endmodule

// File: tb/tb_blink_scheduler.sv
// Testbench for blink_scheduler: a vector table for short-sequence
// behaviour, hand-written long sequences for period/chase/wrap corners, and
// a randomized run against a cycle-level reference model.
module tb_blink_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_chan = 2'b00;
   logic [15:0] cfg_offset = 16'h0000;
   logic        cfg_ready;
   logic [15:0] count;
   logic [63:0] offsets;
   logic        period_tick;
   logic [1:0]  state;

   blink_scheduler dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
      .cfg_valid(cfg_valid), .cfg_chan(cfg_chan), .cfg_offset(cfg_offset),
      .cfg_ready(cfg_ready), .count(count), .offsets(offsets),
      .period_tick(period_tick), .state(state)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic edges(input int n);
      repeat (n) edge1();
   endtask

   function automatic logic [63:0] pack(input int a0, input int a1, input int a2, input int a3);
      return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
   endfunction

   // ---------------- reference model ----------------
   // state: 0 idle, 1 static run, 2 chasing
   int m_count, m_state, m_tick;
   int m_off[4];

   task automatic model_reset();
      m_count = 0; m_state = 0; m_tick = 0;
      for (int i = 0; i < 4; i++) m_off[i] = 256 * i;
   endtask

   task automatic model_edge();
      bit running, adv, period_end, accept;
      int ns;
      if (!rst_n) begin
         model_reset();
         return;
      end
      running    = (m_state != 0);
      adv        = ena && running && (mode != 2'b00);
      period_end = adv && ((m_count % 1024) == 1023);
      accept     = cfg_valid && (m_state != 2);
      if (mode == 2'b00)      ns = 0;
      else if (!running)      ns = 1;
      else if (!period_end)   ns = m_state;
      else                    ns = (mode == 2'b10) ? 2 : 1;
      if (adv) m_count = (m_count + 1) % 65536;
      if (period_end && ns == 2)
         for (int i = 0; i < 4; i++) m_off[i] = (m_off[i] + 64) % 65536;
      if (accept) m_off[cfg_chan] = cfg_offset;
      m_tick  = period_end ? 1 : 0;
      m_state = ns;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst_n, ena;
      logic [1:0]  mode;
      logic        cv;
      logic [1:0]  cc;
      logic [15:0] co;
      logic [1:0]  e_state;
      logic [15:0] e_count;
      logic        e_tick, e_ready;
      logic [63:0] e_off;
   } vec_t;

   localparam logic [63:0] DEF = 64'h0300_0200_0100_0000;
   localparam logic [63:0] W3  = 64'h00AA_0200_0100_0000;
   localparam logic [63:0] W31 = 64'h00AA_0200_1234_0000;

   vec_t tbl[11];

   initial begin
      int bad;
      int r;

      tbl[0]  = '{1'b0, 1'b0, 2'b01, 1'b0, 2'd0, 16'h0000, 2'b00, 16'd0, 1'b0, 1'b1, DEF};
      tbl[1]  = '{1'b1, 1'b1, 2'b01, 1'b0, 2'd0, 16'h0000, 2'b01, 16'd0, 1'b0, 1'b1, DEF};
      tbl[2]  = '{1'b1, 1'b1, 2'b01, 1'b0, 2'd0, 16'h0000, 2'b01, 16'd1, 1'b0, 1'b1, DEF};
      tbl[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 2'd0, 16'h0000, 2'b01, 16'd1, 1'b0, 1'b1, DEF};
      tbl[4]  = '{1'b1, 1'b1, 2'b11, 1'b0, 2'd0, 16'h0000, 2'b01, 16'd2, 1'b0, 1'b1, DEF};
      tbl[5]  = '{1'b1, 1'b1, 2'b00, 1'b0, 2'd0, 16'h0000, 2'b00, 16'd2, 1'b0, 1'b1, DEF};
      tbl[6]  = '{1'b1, 1'b1, 2'b00, 1'b1, 2'd3, 16'h00AA, 2'b00, 16'd2, 1'b0, 1'b1, W3};
      tbl[7]  = '{1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 16'h0000, 2'b01, 16'd2, 1'b0, 1'b1, W3};
      tbl[8]  = '{1'b1, 1'b1, 2'b10, 1'b0, 2'd0, 16'h0000, 2'b01, 16'd3, 1'b0, 1'b1, W3};
      tbl[9]  = '{1'b1, 1'b1, 2'b00, 1'b1, 2'd1, 16'h1234, 2'b00, 16'd3, 1'b0, 1'b1, W31};
      tbl[10] = '{1'b0, 1'b1, 2'b01, 1'b1, 2'd2, 16'h5555, 2'b00, 16'd0, 1'b0, 1'b1, DEF};

      for (int i = 0; i < 11; i++) begin
         rst_n = tbl[i].rst_n; ena = tbl[i].ena; mode = tbl[i].mode;
         cfg_valid = tbl[i].cv; cfg_chan = tbl[i].cc; cfg_offset = tbl[i].co;
         edge1();
         chk($sformatf("vec%0d_state", i), 64'(state), 64'(tbl[i].e_state));
         chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_count));
         chk($sformatf("vec%0d_tick", i), 64'(period_tick), 64'(tbl[i].e_tick));
         chk($sformatf("vec%0d_ready", i), 64'(cfg_ready), 64'(tbl[i].e_ready));
         chk($sformatf("vec%0d_off", i), offsets, tbl[i].e_off);
      end

      // ---- first period from reset ----
      rst_n = 1'b1; cfg_valid = 1'b0; ena = 1'b1; mode = 2'b01;
      edge1();
      chk("run_after_1_edge", 64'(state), 64'd1);
      chk("count_held_on_start", 64'(count), 64'd0);
      edges(1023);
      chk("count_3ff", 64'(count), 64'h3FF);
      chk("no_tick_before_wrap", 64'(period_tick), 64'd0);
      edge1();
      chk("count_400", 64'(count), 64'h400);
      chk("tick_at_400", 64'(period_tick), 64'd1);
      edge1();
      chk("tick_one_cycle", 64'(period_tick), 64'd0);

      // ---- chase request mid-period waits for the wrap ----
      edges(16'h600 - 16'h401);
      chk("count_600", 64'(count), 64'h600);
      mode = 2'b10;
      edges(16'h7FF - 16'h600);
      chk("run_until_wrap", 64'(state), 64'd1);
      chk("offsets_before_chase", offsets, DEF);
      edge1();
      chk("chase_entered", 64'(state), 64'd2);
      chk("chase_first_inc", offsets, pack(64, 320, 576, 832));
      chk("chase_ready_low", 64'(cfg_ready), 64'd0);

      // ---- four chase periods, writes ignored, then return to RUN ----
      cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_offset = 16'hDEAD;
      bad = 0;
      for (int i = 0; i < 4096; i++) begin
         edge1();
         if (cfg_ready !== 1'b0 || state !== 2'd2) bad++;
      end
      chk("chase_ready_low_4periods", 64'(bad), 64'd0);
      chk("chase_offsets_4periods", offsets, pack(320, 576, 832, 1088));
      mode = 2'b01;
      edges(1023);
      chk("chase_holds_until_wrap", 64'(state), 64'd2);
      edge1();
      cfg_valid = 1'b0;
      chk("back_to_run", 64'(state), 64'd1);
      chk("exit_no_inc", offsets, pack(320, 576, 832, 1088));
      chk("count_1c00", 64'(count), 64'h1C00);

      // ---- cfg write in RUN ----
      cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_offset = 16'hBEEF;
      edge1();
      cfg_valid = 1'b0;
      chk("write_beef", offsets, pack(320, 576, 16'hBEEF, 1088));

      // ---- write on the RUN->CHASE edge beats the increment ----
      mode = 2'b10;
      edges(16'h1FFF - 16'h1C01);
      cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_offset = 16'h0101;
      edge1();
      cfg_valid = 1'b0;
      chk("chase_entered_2", 64'(state), 64'd2);
      chk("write_beats_inc", offsets, pack(384, 16'h0101, 16'hBF2F, 1152));

      // ---- reset mid-chase with a pending write ----
      rst_n = 1'b0; cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_offset = 16'h7777;
      edge1();
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_offsets", offsets, DEF);
      chk("rst_tick", 64'(period_tick), 64'd0);
      chk("rst_ready", 64'(cfg_ready), 64'd1);
      rst_n = 1'b1; cfg_valid = 1'b0;

      // ---- 16-bit count wrap, then enable freeze ----
      mode = 2'b01; ena = 1'b1;
      edge1();
      edges(65535);
      chk("count_ffff", 64'(count), 64'hFFFF);
      edge1();
      chk("count_wraps_0", 64'(count), 64'h0);
      chk("tick_on_wrap", 64'(period_tick), 64'd1);
      ena = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         edge1();
         if (count !== 16'h0 || period_tick !== 1'b0) bad++;
      end
      chk("ena_freeze", 64'(bad), 64'd0);
      chk("ena_freeze_state", 64'(state), 64'd1);

      // ---- randomized run against the reference model ----
      rst_n = 1'b0;
      model_edge();
      edge1();
      rst_n = 1'b1;
      mode = 2'b01;
      for (int c = 0; c < 4000; c++) begin
         rst_n = ($urandom_range(1999) != 0);
         ena = ($urandom_range(7) != 0);
         if ($urandom_range(63) == 0) begin
            r = $urandom_range(9);
            mode = (r == 0) ? 2'b00 : (r < 5) ? 2'b10 : (r < 8) ? 2'b01 : 2'b11;
         end
         cfg_valid = ($urandom_range(3) == 0);
         cfg_chan = 2'($urandom_range(3));
         cfg_offset = 16'($urandom);
         model_edge();
         edge1();
         chk("rnd_state", 64'(state), 64'(m_state));
         chk("rnd_count", 64'(count), 64'(m_count));
         chk("rnd_tick", 64'(period_tick), 64'(m_tick));
         chk("rnd_ready", 64'(cfg_ready), 64'(m_state != 2));
         chk("rnd_offsets", offsets, pack(m_off[0], m_off[1], m_off[2], m_off[3]));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
